// File: rtl/dram_cmd_sequencer.sv
// dram_cmd_sequencer: host-side command sequencer for a bit-serial, 8-bank DRAM
// with a per-bank row buffer. It accepts word-wide read/write requests, splits
// them into per-column device accesses, and tracks the open row per bank so
// that read hits skip activation.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready is high only while idle)
//   req_write         1 = write, 0 = read
//   req_bank/row      target bank and row
//   req_wdata         write word, bit c goes to column c
//   rsp_valid         one-cycle completion pulse for reads and writes
//   rsp_rdata         read word, valid with rsp_valid (held across writes)
//   dram_rw           1 = column write
//   dram_buff_rw      row-buffer load strobe
//   dram_bank_id/rowid/colid  device address
//   dram_wdata/_oe    split write data bus; oe mirrors dram_rw
//   dram_rdata        device read data, registered by the device
module dram_cmd_sequencer #(
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned NUM_OF_ROWS  = 128,
  parameter int unsigned NUM_OF_COLS  = 8,
  parameter int unsigned ACT_CYCLES   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row,
  input  logic [NUM_OF_COLS-1:0]          req_wdata,
  output logic                            rsp_valid,
  output logic [NUM_OF_COLS-1:0]          rsp_rdata,
  output logic                            dram_rw,
  output logic                            dram_buff_rw,
  output logic [$clog2(NUM_OF_BANKS)-1:0] dram_bank_id,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  dram_rowid,
  output logic [$clog2(NUM_OF_COLS)-1:0]  dram_colid,
  output logic                            dram_wdata,
  output logic                            dram_wdata_oe,
  input  logic                            dram_rdata
);

  localparam int unsigned BANK_W = $clog2(NUM_OF_BANKS);
  localparam int unsigned ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int unsigned COL_W  = $clog2(NUM_OF_COLS);
  localparam int unsigned ACT_W  = (ACT_CYCLES > 1) ? $clog2(ACT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACT   = 3'd1,
    WR    = 3'd2,
    RD    = 3'd3,
    DRAIN = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t                  state;
  logic [BANK_W-1:0]       lat_bank;
  logic [ROW_W-1:0]        lat_row;
  logic [NUM_OF_COLS-1:0]  lat_wdata;
  logic [ACT_W-1:0]        act_cnt;

  // Open-row table: one valid bit and one row number per bank.
  logic [NUM_OF_BANKS-1:0] open_vld;
  logic [ROW_W-1:0]        open_row [NUM_OF_BANKS];

  // Capture pipeline: the device returns column c one cycle after it is
  // addressed, so the column index is delayed by one cycle before use.
  logic                    cap_vld;
  logic [COL_W-1:0]        cap_col;

  // Sequencer FSM with registered outputs; dram_colid doubles as column counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      dram_rw       <= 1'b0;
      dram_buff_rw  <= 1'b0;
      dram_bank_id  <= '0;
      dram_rowid    <= '0;
      dram_colid    <= '0;
      dram_wdata    <= 1'b0;
      dram_wdata_oe <= 1'b0;
      lat_bank      <= '0;
      lat_row       <= '0;
      lat_wdata     <= '0;
      act_cnt       <= '0;
      open_vld      <= '0;
      cap_vld       <= 1'b0;
      cap_col       <= '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        open_row[b] <= '0;
      end
    end else begin
      rsp_valid <= 1'b0;
      cap_vld   <= 1'b0;
      if (cap_vld) begin
        rsp_rdata[cap_col] <= dram_rdata;
      end

      case (state)
        IDLE: begin
          req_ready     <= 1'b1;
          dram_rw       <= 1'b0;
          dram_wdata_oe <= 1'b0;
          dram_buff_rw  <= 1'b0;
          dram_colid    <= '0;
          if (req_valid && req_ready) begin
            req_ready    <= 1'b0;
            lat_bank     <= req_bank;
            lat_row      <= req_row;
            lat_wdata    <= req_wdata;
            dram_bank_id <= req_bank;
            dram_rowid   <= req_row;
            if (req_write) begin
              state         <= WR;
              dram_rw       <= 1'b1;
              dram_wdata_oe <= 1'b1;
              dram_wdata    <= req_wdata[0];
            end else if (open_vld[req_bank] && (open_row[req_bank] == req_row)) begin
              state <= RD;
            end else begin
              state        <= ACT;
              dram_buff_rw <= 1'b1;
              act_cnt      <= '0;
            end
          end
        end

        ACT: begin
          if (act_cnt == ACT_W'(ACT_CYCLES - 1)) begin
            dram_buff_rw       <= 1'b0;
            act_cnt            <= '0;
            open_vld[lat_bank] <= 1'b1;
            open_row[lat_bank] <= lat_row;
            dram_colid         <= '0;
            state              <= RD;
          end else begin
            act_cnt <= act_cnt + ACT_W'(1);
          end
        end

        RD: begin
          cap_vld <= 1'b1;
          cap_col <= dram_colid;
          if (dram_colid == COL_W'(NUM_OF_COLS - 1)) begin
            dram_colid <= '0;
            state      <= DRAIN;
          end else begin
            dram_colid <= dram_colid + COL_W'(1);
          end
        end

        // Last column lands in rsp_rdata on this edge via the capture pipeline.
        DRAIN: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        WR: begin
          if (dram_colid == COL_W'(NUM_OF_COLS - 1)) begin
            dram_rw            <= 1'b0;
            dram_wdata_oe      <= 1'b0;
            dram_wdata         <= 1'b0;
            dram_colid         <= '0;
            // Device row buffer for this bank no longer matches the array.
            open_vld[lat_bank] <= 1'b0;
            rsp_valid          <= 1'b1;
            state              <= RESP;
          end else begin
            dram_colid <= dram_colid + COL_W'(1);
            dram_wdata <= lat_wdata[COL_W'(dram_colid + COL_W'(1))];
          end
        end

        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Testbench for dram_cmd_sequencer: a behavioural bit-serial DRAM device,
// a directed vector table, a mid-operation reset sequence, and random traffic
// checked against a word-level reference model.
module tb_dram_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [2:0] req_bank = '0;
  logic [6:0] req_row = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       dram_rw;
  logic       dram_buff_rw;
  logic [2:0] dram_bank_id;
  logic [6:0] dram_rowid;
  logic [2:0] dram_colid;
  logic       dram_wdata;
  logic       dram_wdata_oe;
  logic       dram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dram_cmd_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_bank      (req_bank),
    .req_row       (req_row),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .dram_rw       (dram_rw),
    .dram_buff_rw  (dram_buff_rw),
    .dram_bank_id  (dram_bank_id),
    .dram_rowid    (dram_rowid),
    .dram_colid    (dram_colid),
    .dram_wdata    (dram_wdata),
    .dram_wdata_oe (dram_wdata_oe),
    .dram_rdata    (dram_rdata)
  );

  // Device: column writes go straight to the array; reads come from the
  // bank's row buffer, which is loaded by buff_rw. Read data is registered.
  logic [7:0] dev_mem [8][128] = '{default: '0};
  logic [7:0] dev_buf [8]      = '{default: '0};
  logic       dev_q            = 1'b0;
  assign dram_rdata = dev_q;

  always @(posedge clk) begin
    if (dram_buff_rw) dev_buf[dram_bank_id] <= dev_mem[dram_bank_id][dram_rowid];
    if (dram_rw) dev_mem[dram_bank_id][dram_rowid][dram_colid] <= dram_wdata;
    dev_q <= dev_buf[dram_bank_id][dram_colid];
  end

  // Word-level reference: memory contents, open-row table, last response word.
  logic [7:0] ref_mem [8][128] = '{default: '0};
  logic [7:0] ref_vld  = '0;
  logic [6:0] ref_row [8] = '{default: '0};
  logic [7:0] ref_last = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Predict latency, activation cycles and response word, then update the model.
  task automatic model_step(input bit wr, input logic [2:0] bank, input logic [6:0] row,
                            input logic [7:0] wdata,
                            output int lat, output int act, output logic [7:0] rdata);
    bit hit;
    hit = ref_vld[bank] && (ref_row[bank] == row);
    if (wr) begin
      lat = 9; act = 0; rdata = ref_last;
      ref_mem[bank][row] = wdata;
      ref_vld[bank] = 1'b0;
    end else begin
      lat = hit ? 10 : 12;
      act = hit ? 0 : 2;
      rdata = ref_mem[bank][row];
      ref_vld[bank] = 1'b1;
      ref_row[bank] = row;
      ref_last = rdata;
    end
  endtask

  // Issue one request at a negedge and observe it cycle by cycle.
  task automatic run_txn(input bit wr, input logic [2:0] bank, input logic [6:0] row,
                         input logic [7:0] wdata,
                         output int lat, output int act, output logic [7:0] rdata,
                         output bit wr_ok, output bit proto_ok);
    int k;
    int wi;
    lat = -1; act = 0; rdata = '0; wr_ok = 1'b1; proto_ok = 1'b1; wi = 0;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) begin
      proto_ok = 1'b0;
      wr_ok = 1'b0;
      return;
    end
    req_valid = 1'b1; req_write = wr; req_bank = bank; req_row = row; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 8'($urandom);
    for (int c = 1; c <= 30; c++) begin
      if (dram_buff_rw) begin
        act++;
        if (dram_bank_id !== bank || dram_rowid !== row) proto_ok = 1'b0;
      end
      if (dram_rw) begin
        if (wi >= 8 || dram_colid !== 3'(wi) || dram_wdata !== wdata[wi[2:0]] ||
            dram_wdata_oe !== 1'b1 || dram_bank_id !== bank || dram_rowid !== row)
          wr_ok = 1'b0;
        wi++;
      end else if (dram_wdata_oe !== 1'b0) begin
        wr_ok = 1'b0;
      end
      if (req_ready !== 1'b0) proto_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = c;
        rdata = rsp_rdata;
        break;
      end
      @(negedge clk);
    end
    if (wi != (wr ? 8 : 0)) wr_ok = 1'b0;
    if (lat > 0) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) proto_ok = 1'b0;
    end
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] bank;
    logic [6:0] row;
    logic [7:0] wdata;
    int         lat;
    int         act;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, act, m_lat, m_act;
    logic [7:0] rdata, m_rdata;
    bit wr_ok, proto_ok, seen_rsp;
    bit wr;
    logic [2:0] bank;
    logic [6:0] row;
    logic [7:0] wdata;

    // Directed table; rdata for writes is the held previous response word.
    vecs[0] = '{1'b1, 3'd3, 7'd5, 8'hA5, 9,  0, 8'h00};
    vecs[1] = '{1'b0, 3'd3, 7'd5, 8'h00, 12, 2, 8'hA5};
    vecs[2] = '{1'b0, 3'd3, 7'd5, 8'h00, 10, 0, 8'hA5};
    vecs[3] = '{1'b1, 3'd2, 7'd7, 8'h3C, 9,  0, 8'hA5};
    vecs[4] = '{1'b0, 3'd3, 7'd5, 8'h00, 10, 0, 8'hA5};
    vecs[5] = '{1'b0, 3'd2, 7'd7, 8'h00, 12, 2, 8'h3C};
    vecs[6] = '{1'b0, 3'd3, 7'd6, 8'h00, 12, 2, 8'h00};
    vecs[7] = '{1'b0, 3'd3, 7'd6, 8'h00, 10, 0, 8'h00};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs",
          32'({req_ready, rsp_valid, rsp_rdata, dram_rw, dram_buff_rw, dram_bank_id,
               dram_rowid, dram_colid, dram_wdata, dram_wdata_oe}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready after reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].wr, vecs[i].bank, vecs[i].row, vecs[i].wdata, lat, act, rdata, wr_ok, proto_ok);
      model_step(vecs[i].wr, vecs[i].bank, vecs[i].row, vecs[i].wdata, m_lat, m_act, m_rdata);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d act cycles", i), 32'(act), 32'(vecs[i].act));
      check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].rdata));
      check($sformatf("vec%0d write columns", i), 32'(wr_ok), 32'd1);
      check($sformatf("vec%0d handshake", i), 32'(proto_ok), 32'd1);
    end

    // Reset during the read of column 4 of a hit on bank 3, row 6.
    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_bank = 3'd3; req_row = 7'd6;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset colid before", 32'(dram_colid), 32'd4);
    check("midreset rw before", 32'(dram_rw), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midreset outputs",
          32'({req_ready, rsp_valid, rsp_rdata, dram_rw, dram_buff_rw, dram_bank_id,
               dram_rowid, dram_colid, dram_wdata, dram_wdata_oe}), 32'd0);
    rst = 1'b0;
    ref_vld = '0;
    ref_last = '0;
    seen_rsp = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_rsp = 1'b1;
    end
    check("midreset no response", 32'(seen_rsp), 32'd0);
    run_txn(1'b0, 3'd3, 7'd6, 8'h00, lat, act, rdata, wr_ok, proto_ok);
    model_step(1'b0, 3'd3, 7'd6, 8'h00, m_lat, m_act, m_rdata);
    check("postreset latency", 32'(lat), 32'd12);
    check("postreset act cycles", 32'(act), 32'd2);
    check("postreset rdata", 32'(rdata), 32'h00);

    // Random traffic against the reference model; few rows per bank for hits.
    for (int i = 0; i < 40; i++) begin
      wr    = 1'($urandom);
      bank  = 3'($urandom_range(0, 7));
      row   = 7'($urandom_range(0, 3));
      wdata = 8'($urandom);
      run_txn(wr, bank, row, wdata, lat, act, rdata, wr_ok, proto_ok);
      model_step(wr, bank, row, wdata, m_lat, m_act, m_rdata);
      check($sformatf("rnd%0d latency", i), 32'(lat), 32'(m_lat));
      check($sformatf("rnd%0d act cycles", i), 32'(act), 32'(m_act));
      check($sformatf("rnd%0d rdata", i), 32'(rdata), 32'(m_rdata));
      check($sformatf("rnd%0d write columns", i), 32'(wr_ok), 32'd1);
      check($sformatf("rnd%0d handshake", i), 32'(proto_ok), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_cmd_sequencer.md
Name: dram_cmd_sequencer

Overview:
- Host-side command sequencer sitting directly upstream of the bit-serial DRAM device (8 banks, 1-bit columns, per-bank row buffer).
- Accepts word-wide read/write requests and serializes them into per-column accesses.
- Tracks the open row per bank, so read hits skip activation.
- Drives the device's rw / buff_rw / bank_id / rowid / colid controls and a split data bus; the top level merges the split bus onto the device's tri-state pin.

Parameters:
- NUM_OF_BANKS, 8, number of banks.
- NUM_OF_ROWS, 128, rows per bank.
- NUM_OF_COLS, 8, columns per row; also the host word width (1 bit per column).
- ACT_CYCLES, 2, cycles buff_rw is held high to load a bank's row buffer.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_write  in  1  1=write, 0=read.
- req_bank  in  $clog2(NUM_OF_BANKS)  target bank.
- req_row  in  $clog2(NUM_OF_ROWS)  target row.
- req_wdata  in  NUM_OF_COLS  write word; bit c goes to column c.
- rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
- rsp_rdata  out  NUM_OF_COLS  read word, valid with rsp_valid.
- dram_rw  out  1  1=column write, 0=read/idle.
- dram_buff_rw  out  1  row-buffer load strobe.
- dram_bank_id  out  $clog2(NUM_OF_BANKS)  bank select.
- dram_rowid  out  $clog2(NUM_OF_ROWS)  row select.
- dram_colid  out  $clog2(NUM_OF_COLS)  column select.
- dram_wdata  out  1  write bit.
- dram_wdata_oe  out  1  equals dram_rw; top level drives the device data pin only when high.
- dram_rdata  in  1  device data pin as read back; registered by the device one cycle after colid is presented.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, all dram_* outputs=0.
- Reset clears the open-row table and enters IDLE on the next edge.
- Reset asserted mid-operation aborts the operation with no response and forces all outputs to their reset values on the following cycle.

State machine: IDLE, ACT, WR, RD, DRAIN, RESP.
- IDLE:
  - req_ready=1; dram_rw=0, dram_buff_rw=0.
  - On req_valid&&req_ready, latch bank/row/write/wdata. req_ready drops the cycle after acceptance.
  - Write: go to WR.
  - Read hit (open_vld[bank] && open_row[bank]==row): go to RD.
  - Read miss: go to ACT.
- ACT:
  - dram_buff_rw=1 for exactly ACT_CYCLES cycles, with bank/row driven.
  - Then open_vld[bank]<=1, open_row[bank]<=row; go to RD.
- RD:
  - NUM_OF_COLS cycles; colid counts 0..NUM_OF_COLS-1 with rw=0.
  - The rdata bit for column c is captured on the edge one cycle after c is presented, into rsp_rdata[c].
- DRAIN:
  - One cycle to capture the last column; then go to RESP.
- WR:
  - NUM_OF_COLS cycles; rw=1, wdata_oe=1, colid counts 0..NUM_OF_COLS-1, wdata=req_wdata[colid].
  - On exit, open_vld[bank]<=0, because the device's row buffer for that bank is now stale. Other banks' entries are untouched.
  - Then go to RESP.
- RESP:
  - rsp_valid=1 for one cycle. For writes, rsp_rdata holds its previous value.
  - Then go to IDLE.
- Latency, counted from the accept edge to the rsp_valid cycle inclusive:
  - Write = NUM_OF_COLS+1 (9).
  - Read hit = NUM_OF_COLS+2 (10).
  - Read miss = ACT_CYCLES+NUM_OF_COLS+2 (12).
- Back-to-back: the earliest next acceptance is the cycle after RESP. There is no pipelining across requests.
- Column counter wraps to 0 at state exit; there is no out-of-range column access.
- Row change on an open bank is a miss and reactivates (no explicit precharge).
- rsp has no backpressure; the host must be able to take a pulse.

Test Plan:
- Write bank 3, row 5, wdata 0xA5 -> 8 WR cycles with colid 0..7 and wdata bits 1,0,1,0,0,1,0,1; rsp_valid pulses at cycle 9; open_vld[3]=0.
- Read bank 3, row 5 after that write -> miss: 2 cycles with buff_rw=1, rsp_rdata=0xA5 at cycle 12.
- Repeat the same read -> hit: no buff_rw, rsp_rdata=0xA5 at cycle 10.
- Write bank 2, row 7, 0x3C; read bank 3, row 5 -> still a hit (bank 3 entry kept), 0xA5. Read bank 2, row 7 -> miss, 0x3C.
- Read bank 3, row 6 (never written) -> miss; ACT reloads; rsp_rdata=0x00; open_row[3]=6.
- Assert rst during the RD cycle for column 4 -> next cycle all outputs are 0 and no rsp_valid. After release, a read of bank 3, row 6 is a miss (table cleared).
